// File: rtl/sr_latch_pkg.sv
// Shared constants for the SR ring: {S,R} drive codes and the default ring length.
package sr_latch_pkg;

    localparam int N_DEFAULT = 8;

    localparam logic [1:0] SR_HOLD    = 2'b00;
    localparam logic [1:0] SR_RESET   = 2'b01;
    localparam logic [1:0] SR_SET     = 2'b10;
    localparam logic [1:0] SR_ILLEGAL = 2'b11;

endpackage

// File: rtl/sr_cell.sv
// Clocked SR storage element with enable and synchronous active-high clear.
module sr_cell
    import sr_latch_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic s,
    input  logic r,
    output logic q
);

    logic r_q;
    logic [1:0] w_code;

    assign w_code = {s, r};

    // rst_n is the legacy name of an active-high clear.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_q <= 1'b0;
        end else if (en) begin
            case (w_code)
                SR_SET:   r_q <= 1'b1;
                SR_RESET: r_q <= 1'b0;
                default:  r_q <= r_q;   // hold, and hold on the illegal 11 code
            endcase
        end
    end

    assign q = r_q;

endmodule

// File: rtl/sr_latch_net.sv
// Ring of N SR cells with inverted feedback into stage 0, forming a 2N-state Johnson sequence.
module sr_latch_net
    import sr_latch_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enabled,
    output logic b
);

    logic [N-1:0] w_q;
    logic [N-1:0] w_s;
    logic [N-1:0] w_r;

    assign w_s[0] = ~w_q[N-1];
    assign w_r[0] =  w_q[N-1];

    genvar i;
    generate
        for (i = 1; i < N; i++) begin : g_drive
            assign w_s[i] =  w_q[i-1];
            assign w_r[i] = ~w_q[i-1];
        end

        for (i = 0; i < N; i++) begin : g_stage
            sr_cell u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (enabled),
                .s     (w_s[i]),
                .r     (w_r[i]),
                .q     (w_q[i])
            );
        end
    endgenerate

    assign b = w_q[0];

endmodule

// File: tb/tb_sr_latch_net.sv
// Randomized and directed checks of sr_latch_net (N=8 and N=2) and of sr_cell alone.
module tb_sr_latch_net;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic enabled;
    logic b8;
    logic b2;

    logic c_rst, c_en, c_s, c_r, c_q;

    int k;
    int errors = 0;
    int checks = 0;

    sr_latch_net #(.N(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enabled (enabled),
        .b       (b8)
    );

    sr_latch_net #(.N(2)) dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .enabled (enabled),
        .b       (b2)
    );

    sr_cell u_cell (
        .clk   (clk),
        .rst_n (c_rst),
        .en    (c_en),
        .s     (c_s),
        .r     (c_r),
        .q     (c_q)
    );

    // Stage i shows stage 0 delayed i steps; stage 0 is high for steps 1..n of each 2n period.
    function automatic logic [7:0] exp_q(input int kk, input int n);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            int m;
            m = kk - i;
            v[i] = (m > 0) && (((m - 1) % (2 * n)) < n);
        end
        return v;
    endfunction

    task automatic tick(input logic rst, input logic en);
        rst_n   = rst;
        enabled = en;
        @(posedge clk);
        #1;
        if (rst) k = 0;
        else if (en) k++;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            tick(1'b1, 1'b1);
            checks++;
            if (dut.w_q !== 8'h00 || b8 !== 1'b0) begin
                errors++;
                $display("FAIL reset8 cyc%0d: q=%b b=%b expected q=00000000 b=0", c, dut.w_q, b8);
            end
            checks++;
            if (dut2.w_q !== 2'b00 || b2 !== 1'b0) begin
                errors++;
                $display("FAIL reset2 cyc%0d: q=%b b=%b expected q=00 b=0", c, dut2.w_q, b2);
            end
        end
    endtask

    task automatic test_basic();
        logic exp_b;
        tick(1'b1, 1'b0);
        for (int e = 1; e <= 17; e++) begin
            tick(1'b0, 1'b1);
            exp_b = (e <= 8) || (e == 17);
            checks++;
            if (b8 !== exp_b) begin
                errors++;
                $display("FAIL basic_b edge%0d: b=%b expected %b", e, b8, exp_b);
            end
            if (e == 3) begin
                checks++;
                if (dut.w_q !== 8'b0000_0111) begin
                    errors++;
                    $display("FAIL basic_q3: q=%b expected 00000111", dut.w_q);
                end
            end
        end
    endtask

    task automatic test_hold();
        tick(1'b1, 1'b0);
        for (int e = 0; e < 3; e++) tick(1'b0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (dut.w_q !== 8'b0000_0111) begin
                errors++;
                $display("FAIL hold cyc%0d: q=%b expected 00000111", c, dut.w_q);
            end
        end
        tick(1'b0, 1'b1);
        checks++;
        if (dut.w_q !== 8'b0000_1111) begin
            errors++;
            $display("FAIL hold_resume: q=%b expected 00001111", dut.w_q);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 1'b0);
        for (int e = 0; e < 9; e++) tick(1'b0, 1'b1);
        checks++;
        if (dut.w_q !== 8'b1111_1110) begin
            errors++;
            $display("FAIL mid_pre: q=%b expected 11111110", dut.w_q);
        end
        tick(1'b1, 1'b1);
        checks++;
        if (dut.w_q !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: q=%b expected 00000000", dut.w_q);
        end
        tick(1'b0, 1'b1);
        checks++;
        if (b8 !== 1'b1) begin
            errors++;
            $display("FAIL mid_restart: b=%b expected 1", b8);
        end
    endtask

    task automatic test_n2();
        logic [1:0] seq [4];
        seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        tick(1'b1, 1'b0);
        checks++;
        if (dut2.w_q !== 2'b00) begin
            errors++;
            $display("FAIL n2_reset: q=%b expected 00", dut2.w_q);
        end
        for (int e = 0; e < 4; e++) begin
            tick(1'b0, 1'b1);
            checks++;
            if (dut2.w_q !== seq[e]) begin
                errors++;
                $display("FAIL n2_seq edge%0d: q=%b expected %b", e + 1, dut2.w_q, seq[e]);
            end
        end
    endtask

    task automatic test_cell();
        logic [1:0] sr [5];
        logic       m;
        sr = '{2'b10, 2'b00, 2'b11, 2'b01, 2'b00};
        c_rst = 1'b1; c_en = 1'b1; c_s = 1'b1; c_r = 1'b0;
        @(posedge clk); #1;
        m = 1'b0;
        checks++;
        if (c_q !== m) begin
            errors++;
            $display("FAIL cell_reset: q=%b expected %b", c_q, m);
        end
        c_rst = 1'b0;
        for (int t = 0; t < 5; t++) begin
            {c_s, c_r} = sr[t];
            @(posedge clk); #1;
            if (c_s && !c_r) m = 1'b1;
            else if (!c_s && c_r) m = 1'b0;
            checks++;
            if (c_q !== m) begin
                errors++;
                $display("FAIL cell_sr%b: q=%b expected %b", sr[t], c_q, m);
            end
        end
        c_en = 1'b0; c_s = 1'b1; c_r = 1'b0;
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #1;
            checks++;
            if (c_q !== m) begin
                errors++;
                $display("FAIL cell_en0: q=%b expected %b", c_q, m);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] e8;
        logic [7:0] e2;
        tick(1'b1, 1'b0);
        for (int c = 0; c < 300; c++) begin
            tick(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
            e8 = exp_q(k, 8);
            e2 = exp_q(k, 2);
            checks++;
            if (dut.w_q !== e8 || b8 !== e8[0]) begin
                errors++;
                $display("FAIL rand8 cyc%0d k=%0d: q=%b b=%b expected q=%b", c, k, dut.w_q, b8, e8);
            end
            checks++;
            if (dut2.w_q !== e2[1:0] || b2 !== e2[0]) begin
                errors++;
                $display("FAIL rand2 cyc%0d k=%0d: q=%b b=%b expected q=%b", c, k, dut2.w_q, b2, e2[1:0]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1; enabled = 1'b0; k = 0;
        c_rst = 1'b1; c_en = 1'b0; c_s = 1'b0; c_r = 1'b0;
        test_reset();
        test_basic();
        test_hold();
        test_reset_mid();
        test_n2();
        test_cell();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
